// File: rtl/e_md_unit.sv
// Execute-stage multiply/divide unit: fixed-latency mult/multu/div/divu that
// owns the HI/LO registers and services mfhi/mflo/mthi/mtlo.
module e_md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] in_data_rs,
    input  logic [31:0] in_data_rt,
    output logic [31:0] out_HI_LO,
    output logic        md_start,
    output logic        md_busy,
    output logic [31:0] out_HI,
    output logic [31:0] out_LO
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(8);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   pend_hi_q;
    logic [DATA_W-1:0]   pend_lo_q;
    logic [CNT_W-1:0]    count_q;

    logic                is_md_op;
    logic                commit;
    logic                accept_move;
    logic                dvs_zero;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] prod_u;
    logic signed [DATA_W:0] dvd_s;
    logic signed [DATA_W:0] dvs_s;
    logic [DATA_W-1:0]   quo_s;
    logic [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]   quo_u;
    logic [DATA_W-1:0]   rem_u;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;
    logic [CNT_W-1:0]    op_cycles;

    assign is_md_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign dvs_zero = (in_data_rt == '0);

    // Arithmetic; signed divide is done at DATA_W+1 bits so MIN_INT / -1 wraps cleanly
    assign prod_s = $signed({{DATA_W{in_data_rs[DATA_W-1]}}, in_data_rs}) *
                    $signed({{DATA_W{in_data_rt[DATA_W-1]}}, in_data_rt});
    assign prod_u = {{DATA_W{1'b0}}, in_data_rs} * {{DATA_W{1'b0}}, in_data_rt};
    assign dvd_s  = $signed({in_data_rs[DATA_W-1], in_data_rs});
    assign dvs_s  = $signed({in_data_rt[DATA_W-1], in_data_rt});

    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (!dvs_zero) begin
            quo_s = DATA_W'(dvd_s / dvs_s);
            rem_s = DATA_W'(dvd_s % dvs_s);
            quo_u = in_data_rs / in_data_rt;
            rem_u = in_data_rs % in_data_rt;
        end
    end

    // Pending result and latency; a zero divisor re-commits the current HI/LO
    always_comb begin
        res_hi    = hi_q;
        res_lo    = lo_q;
        op_cycles = CNT_W'(MULT_CYCLES);
        unique case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                op_cycles = CNT_W'(DIV_CYCLES);
                if (!dvs_zero) begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            OP_DIVU: begin
                op_cycles = CNT_W'(DIV_CYCLES);
                if (!dvs_zero) begin
                    res_hi = rem_u;
                    res_lo = quo_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (is_md_op) state_d = ST_BUSY;
            ST_BUSY: if (count_q == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        md_start    = 1'b0;
        commit      = 1'b0;
        accept_move = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                md_start    = is_md_op;
                accept_move = 1'b1;
            end
            ST_BUSY: commit = (count_q == CNT_W'(1));
            default: ;
        endcase
    end

    // HI/LO, pending result and latency counter; commit outranks a move-to
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            count_q   <= '0;
        end else begin
            if (md_start) begin
                pend_hi_q <= res_hi;
                pend_lo_q <= res_lo;
                count_q   <= op_cycles;
            end else if (state_q == ST_BUSY) begin
                count_q   <= count_q - CNT_W'(1);
            end

            if (commit) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end else if (accept_move && (md_op == OP_MTHI)) begin
                hi_q <= in_data_rs;
            end else if (accept_move && (md_op == OP_MTLO)) begin
                lo_q <= in_data_rs;
            end
        end
    end

    always_comb begin
        unique case (md_op)
            OP_MFHI: out_HI_LO = hi_q;
            OP_MFLO: out_HI_LO = lo_q;
            default: out_HI_LO = '0;
        endcase
    end

    assign md_busy = (state_q == ST_BUSY);
    assign out_HI  = hi_q;
    assign out_LO  = lo_q;

endmodule

// File: tb/tb_e_md_unit.sv
// Scoreboard bench for e_md_unit: directed scenarios then random traffic,
// checked against a cycle-indexed arithmetic reference model.
module tb_e_md_unit;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] in_data_rs;
    logic [31:0] in_data_rt;
    logic [31:0] out_HI_LO;
    logic        md_start;
    logic        md_busy;
    logic [31:0] out_HI;
    logic [31:0] out_LO;

    e_md_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .md_op      (md_op),
        .in_data_rs (in_data_rs),
        .in_data_rt (in_data_rt),
        .out_HI_LO  (out_HI_LO),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .out_HI     (out_HI),
        .out_LO     (out_LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        start;
        logic        busy;
        logic [31:0] hilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: committed HI/LO plus one in-flight result with its start cycle
    int          cyc = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] m_phi = '0;
    logic [31:0] m_plo = '0;
    logic        m_active = 1'b0;
    int          m_start = 0;
    int          m_n = 0;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, c, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("md_start",  e.cyc, 32'(md_start), 32'(e.start));
            chk("md_busy",   e.cyc, 32'(md_busy),  32'(e.busy));
            chk("out_HI_LO", e.cyc, out_HI_LO,     e.hilo);
            chk("out_HI",    e.cyc, out_HI,        e.hi);
            chk("out_LO",    e.cyc, out_LO,        e.lo);
        end
    end

    function automatic void ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hi0, input logic [31:0] lo0,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint          sp;
        longint unsigned up;
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        hi = hi0;
        lo = lo0;
        case (op)
            4'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            4'd2: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            4'd3: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                lo = q[31:0];
                hi = r[31:0];
            end
            4'd4: if (b != 0) begin
                lo = a / b;
                hi = a % b;
            end
            default: ;
        endcase
    endfunction

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rst);
        exp_t        e;
        logic        busy_now;
        logic        st;
        logic [31:0] nh;
        logic [31:0] nl;
        @(posedge clk);
        #1;
        md_op      = op;
        in_data_rs = a;
        in_data_rt = b;
        reset      = rst;
        if (m_active && cyc == m_start + m_n + 1) begin
            m_hi     = m_phi;
            m_lo     = m_plo;
            m_active = 1'b0;
        end
        busy_now = m_active && (cyc > m_start);
        st       = (op >= 4'd1 && op <= 4'd4) && !busy_now;
        e.cyc    = cyc;
        e.start  = st;
        e.busy   = busy_now;
        e.hilo   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
        e.hi     = m_hi;
        e.lo     = m_lo;
        sb_q.push_back(e);
        if (rst) begin
            m_hi     = '0;
            m_lo     = '0;
            m_active = 1'b0;
        end else if (st) begin
            ref_calc(op, a, b, m_hi, m_lo, nh, nl);
            m_phi    = nh;
            m_plo    = nl;
            m_active = 1'b1;
            m_start  = cyc;
            m_n      = (op <= 4'd2) ? int'(MC) : int'(DC);
        end else if (!busy_now && op == 4'd7) begin
            m_hi = a;
        end else if (!busy_now && op == 4'd8) begin
            m_lo = a;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic [3:0] op;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 2))
                0:       op = 4'd0;
                1:       op = 4'd5;
                default: op = 4'd6;
            endcase
            step(op, $urandom, $urandom, 1'b0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] op;
        logic       rst;
        reset      = 1'b1;
        md_op      = 4'd0;
        in_data_rs = '0;
        in_data_rt = '0;
        repeat (2) @(posedge clk);

        // Signed and unsigned multiply of -1 by 2
        step(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        idle(int'(MC));
        step(4'd5, 32'h0, 32'h0, 1'b0);
        step(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        idle(int'(MC));
        step(4'd6, 32'h0, 32'h0, 1'b0);

        // Signed divide, including MIN_INT / -1
        step(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        idle(int'(DC));
        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(int'(DC));
        step(4'd5, 32'h0, 32'h0, 1'b0);

        // Divide by zero leaves preset HI/LO
        step(4'd7, 32'h0000_0011, 32'h0, 1'b0);
        step(4'd8, 32'h0000_0022, 32'h0, 1'b0);
        step(4'd4, 32'h0000_0007, 32'h0, 1'b0);
        idle(int'(DC) + 1);

        // Reset in the third busy cycle aborts the multiply
        step(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        idle(2);
        step(4'd0, 32'h0, 32'h0, 1'b1);
        idle(int'(MC) + 3);

        // Move-to then read, then busy guard against start and move-to
        step(4'd7, 32'h0000_1234, 32'h0, 1'b0);
        step(4'd5, 32'h0, 32'h0, 1'b0);
        step(4'd2, 32'h0000_0003, 32'h0000_0005, 1'b0);
        step(4'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        step(4'd7, 32'hCAFE_0000, 32'h0, 1'b0);
        step(4'd8, 32'hCAFE_0001, 32'h0, 1'b0);
        step(4'd4, 32'h0000_0009, 32'h0000_0002, 1'b0);
        idle(int'(MC));
        step(4'd3, 32'h8000_0001, 32'h0000_0003, 1'b0);
        idle(int'(DC));
        // Back-to-back start in the first non-busy cycle
        step(4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        idle(int'(DC) + 2);

        // Random traffic, including ops while busy and occasional resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            op  = rst ? 4'd0 : 4'($urandom_range(0, 15));
            step(op, pick(), pick(), rst);
        end
        idle(int'(DC) + 2);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e_md_unit.md
Name: e_md_unit

Overview:
- Multiply/divide unit in the Execute stage.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and owns the HI/LO architectural registers.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Its out_HI_LO output is pipelined into the Memory stage's in_HI_LO. Its md_start/md_busy outputs feed the hazard unit, which stalls Decode while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles after the start cycle for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles after the start cycle for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none.
- in_data_rs  input  32  forwarded rs value (operand A / mthi / mtlo source).
- in_data_rt  input  32  forwarded rt value (operand B).
- out_HI_LO  output  32  HI when md_op=5, LO when md_op=6, otherwise 0; combinational from the registers.
- md_start  output  1  combinational; high when md_op is 1-4 and md_busy=0.
- md_busy  output  1  registered; high while an operation is in flight.
- out_HI  output  32  current HI register (debug/verification).
- out_LO  output  32  current LO register (debug/verification).

Behaviour:
- Reset (synchronous, priority over everything):
  - HI=0, LO=0, count=0, md_busy=0.
  - Pending results are discarded.
  - A reset mid-operation aborts it; no HI/LO commit ever follows.
- Internal state: HI, LO, pend_hi, pend_lo (32 bits each) and count (4 bits, sized for the maximum of the two latencies).
- Idle (count=0, md_busy=0):
  - md_op 1-4: md_start=1 combinationally. At the edge, capture results into pend_hi/pend_lo, load count with MULT_CYCLES or DIV_CYCLES, and set md_busy=1.
  - md_op 7: HI <= in_data_rs at the edge.
  - md_op 8: LO <= in_data_rs at the edge.
- Busy:
  - Each edge decrements count.
  - On the edge where count goes 1 -> 0: HI <= pend_hi, LO <= pend_lo, md_busy <= 0.
  - Net timing: md_busy is high for exactly N cycles following the start cycle. New HI/LO values are visible in the cycle md_busy first reads 0.
- Commands arriving while busy:
  - md_op 1-4 or 7-8 is ignored and has no state effect. The hazard unit guarantees this never happens; the bench checks the guard anyway.
  - md_op 5/6 returns the current (old) committed HI/LO.
- Arithmetic:
  - mult: signed 32x32 -> 64; {HI,LO} = product.
  - multu: unsigned 32x32 -> 64; {HI,LO} = product.
  - div: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
- Divide by zero (divisor = 0):
  - The operation still runs for the full DIV_CYCLES with md_busy asserted.
  - HI/LO are left unchanged at commit: pend_hi/pend_lo are loaded with the current HI/LO at start.
- Pipelining: back-to-back start is legal in the cycle md_busy first reads 0.
- Commit vs. pending write: when a commit and an mthi/mtlo fall on the same edge, the commit wins. mthi/mtlo is only accepted when not busy, so this cannot occur legally.
- Output decode: out_HI_LO for md_op 0-4 and 7-15 is 0x00000000.

Test Plan:
- Signed mult: md_op=1, rs=0xFFFFFFFF, rt=0x00000002.
  -> md_start=1 in cycle 0; md_busy high in cycles 1-5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE, md_busy=0.
- Unsigned mult: md_op=2, same operands.
  -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; then md_op=6 gives out_HI_LO=0xFFFFFFFE.
- Signed div: md_op=3, rs=0xFFFFFFF9 (-7), rt=2.
  -> md_busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also run rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo, then md_op=4, rs=7, rt=0.
  -> md_busy for 10 cycles; HI=0x11, LO=0x22 afterwards.
- Mid-operation reset, move-to, and busy guard:
  - Start mult, assert reset in busy cycle 3 -> next cycle md_busy=0, HI=LO=0, and no commit in any later cycle.
  - Then md_op=7 with rs=0x1234 -> HI=0x1234; md_op=5 -> out_HI_LO=0x1234.
  - Issue mult while busy -> md_start=0 and the operands are ignored.
